// File: rtl/axi_ddr_cmd_arbiter.sv
// AXI AW/AR to DDR command arbiter.
// Picks one address channel at a time and forwards its command to the DDR
// command FIFO over a valid/ready handshake. A write is only eligible once
// its whole burst of W beats is buffered. Reads win ties unless the read
// streak limit has been hit, in which case the waiting write goes first.
module axi_ddr_cmd_arbiter #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int DDR_ADDR_WIDTH  = 26,
    parameter int MAX_READ_STREAK = 4,
    parameter int WBEAT_CNT_WIDTH = 6
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]  awaddr,
    input  logic [AXI_ID_WIDTH-1:0]    awid,
    input  logic [3:0]                 awlen,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [AXI_ADDR_WIDTH-1:0]  araddr,
    input  logic [AXI_ID_WIDTH-1:0]    arid,
    input  logic [3:0]                 arlen,
    input  logic                       arvalid,
    output logic                       arready,
    input  logic                       wbeat_push,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic                       cmd_write,
    output logic [DDR_ADDR_WIDTH-1:0]  cmd_addr,
    output logic [AXI_ID_WIDTH-1:0]    cmd_id,
    output logic [4:0]                 cmd_len,
    output logic [WBEAT_CNT_WIDTH-1:0] wbeat_cnt,
    output logic                       err_wbeat_ovf
);

    // Arithmetic width wide enough for the beat counter and a 16-beat burst,
    // plus one bit so the comparison and the sum cannot wrap.
    localparam int CW = ((WBEAT_CNT_WIDTH > 5) ? WBEAT_CNT_WIDTH : 5) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 streak_q, streak_d;
    logic [WBEAT_CNT_WIDTH-1:0] wbeat_cnt_q, wbeat_cnt_d;
    logic                       err_q, err_d;
    logic                       cmd_valid_q, cmd_valid_d;
    logic                       cmd_write_q, cmd_write_d;
    logic [DDR_ADDR_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
    logic [AXI_ID_WIDTH-1:0]    cmd_id_q, cmd_id_d;
    logic [4:0]                 cmd_len_q, cmd_len_d;

    logic [CW-1:0] cnt_ext;
    logic [CW-1:0] aw_beats;
    logic [CW-1:0] cnt_sum;
    logic          wr_elig;
    logic          rd_elig;
    logic          streak_at_max;
    logic          grant_w;
    logic          grant_r;
    logic          cnt_ovf;

    assign cnt_ext  = CW'(wbeat_cnt_q);
    assign aw_beats = CW'(awlen) + CW'(1);

    assign wr_elig       = (state_q == IDLE) && awvalid && (cnt_ext >= aw_beats);
    assign rd_elig       = (state_q == IDLE) && arvalid;
    assign streak_at_max = (streak_q == 4'(MAX_READ_STREAK));

    // Reads win ties until the streak limit, then the eligible write goes.
    assign grant_w = wr_elig && (!rd_elig || streak_at_max);
    assign grant_r = rd_elig && (!wr_elig || !streak_at_max);

    // Reset is folded in so no handshake is offered while held in reset.
    assign awready = grant_w && aresetn;
    assign arready = grant_r && aresetn;

    // A push into a full counter is only lost when no burst drains it the same cycle.
    assign cnt_ovf = wbeat_push && (&wbeat_cnt_q) && !grant_w;

    // Next-state, command capture, streak and beat bookkeeping.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        wbeat_cnt_d = wbeat_cnt_q;
        err_d       = err_q;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_id_d    = cmd_id_q;
        cmd_len_d   = cmd_len_q;
        cnt_sum     = cnt_ext + CW'(wbeat_push) - (grant_w ? aw_beats : CW'(0));

        case (state_q)
            IDLE: begin
                if (grant_w) begin
                    state_d     = ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_write_d = 1'b1;
                    cmd_addr_d  = awaddr[DDR_ADDR_WIDTH-1:0];
                    cmd_id_d    = awid;
                    cmd_len_d   = {1'b0, awlen} + 5'd1;
                end else if (grant_r) begin
                    state_d     = ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_write_d = 1'b0;
                    cmd_addr_d  = araddr[DDR_ADDR_WIDTH-1:0];
                    cmd_id_d    = arid;
                    cmd_len_d   = {1'b0, arlen} + 5'd1;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_d     = IDLE;
                    cmd_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase

        // Streak only grows while a write is actually being passed over.
        if (grant_w) begin
            streak_d = 4'd0;
        end else if (grant_r) begin
            if (!wr_elig) begin
                streak_d = 4'd0;
            end else if (!streak_at_max) begin
                streak_d = streak_q + 4'd1;
            end
        end

        if (cnt_ovf) begin
            err_d = 1'b1;
        end else begin
            wbeat_cnt_d = cnt_sum[WBEAT_CNT_WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command, streak and beat-counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            streak_q    <= 4'd0;
            wbeat_cnt_q <= '0;
            err_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_id_q    <= '0;
            cmd_len_q   <= 5'd0;
        end else begin
            streak_q    <= streak_d;
            wbeat_cnt_q <= wbeat_cnt_d;
            err_q       <= err_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_id_q    <= cmd_id_d;
            cmd_len_q   <= cmd_len_d;
        end
    end

    assign cmd_valid     = cmd_valid_q;
    assign cmd_write     = cmd_write_q;
    assign cmd_addr      = cmd_addr_q;
    assign cmd_id        = cmd_id_q;
    assign cmd_len       = cmd_len_q;
    assign wbeat_cnt     = wbeat_cnt_q;
    assign err_wbeat_ovf = err_q;

    // Address MSBs above the DDR range and the carry bits of the sum are dropped on purpose.
    logic unused_bits;
    assign unused_bits = ^{awaddr[AXI_ADDR_WIDTH-1:DDR_ADDR_WIDTH],
                           araddr[AXI_ADDR_WIDTH-1:DDR_ADDR_WIDTH],
                           cnt_sum[CW-1:WBEAT_CNT_WIDTH]};

endmodule

// File: tb/tb_axi_ddr_cmd_arbiter.sv
// Directed bench for axi_ddr_cmd_arbiter: a per-cycle vector table followed
// by hand-written backpressure, starvation and overflow/reset sequences.
module tb_axi_ddr_cmd_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [3:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [3:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic        wbeat_push;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [25:0] cmd_addr;
    logic [3:0]  cmd_id;
    logic [4:0]  cmd_len;
    logic [5:0]  wbeat_cnt;
    logic        err_wbeat_ovf;

    int n_vec = 0;
    int n_bad = 0;

    always #5 aclk = ~aclk;

    axi_ddr_cmd_arbiter dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .awaddr        (awaddr),
        .awid          (awid),
        .awlen         (awlen),
        .awvalid       (awvalid),
        .awready       (awready),
        .araddr        (araddr),
        .arid          (arid),
        .arlen         (arlen),
        .arvalid       (arvalid),
        .arready       (arready),
        .wbeat_push    (wbeat_push),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_id        (cmd_id),
        .cmd_len       (cmd_len),
        .wbeat_cnt     (wbeat_cnt),
        .err_wbeat_ovf (err_wbeat_ovf)
    );

    typedef struct {
        logic        awv;
        logic [3:0]  awl;
        logic [31:0] awa;
        logic [3:0]  awi;
        logic        arv;
        logic        push;
        logic        crdy;
        logic        e_awr;
        logic        e_arr;
        logic        e_cv;
        logic        e_wr;
        logic [4:0]  e_len;
        logic [25:0] e_addr;
        logic [3:0]  e_id;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic awv, input logic [3:0] awl, input logic [31:0] awa,
                                input logic [3:0] awi, input logic arv, input logic push,
                                input logic crdy, input logic e_awr, input logic e_arr,
                                input logic e_cv, input logic e_wr, input logic [4:0] e_len,
                                input logic [25:0] e_addr, input logic [3:0] e_id,
                                input logic [5:0] e_cnt);
        vec_t v;
        v.awv = awv; v.awl = awl; v.awa = awa; v.awi = awi; v.arv = arv;
        v.push = push; v.crdy = crdy; v.e_awr = e_awr; v.e_arr = e_arr;
        v.e_cv = e_cv; v.e_wr = e_wr; v.e_len = e_len; v.e_addr = e_addr;
        v.e_id = e_id; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        awaddr = '0; awid = '0; awlen = '0; awvalid = 1'b0;
        araddr = 32'h1234_5678; arid = 4'd5; arlen = 4'd7; arvalid = 1'b0;
        wbeat_push = 1'b0; cmd_ready = 1'b1;
    endtask

    task automatic do_reset();
        tick();
        idle_inputs();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
    endtask

    string got_order;
    string exp_order;
    int    n_grants;

    initial begin
        idle_inputs();
        aresetn = 1'b0;

        // Read channel is fixed at 0x1234_5678 / id 5 / len 7 throughout the table.
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 0, 0, 0, 0, 0, 26'h0,       0, 0));
        vecs.push_back(mk(1, 3, 32'hABCD_0010, 3, 0, 1, 1, 0, 0, 0, 0, 0, 26'h0,       0, 0));
        vecs.push_back(mk(1, 3, 32'hABCD_0010, 3, 0, 1, 1, 0, 0, 0, 0, 0, 26'h0,       0, 1));
        vecs.push_back(mk(1, 3, 32'hABCD_0010, 3, 0, 1, 1, 0, 0, 0, 0, 0, 26'h0,       0, 2));
        vecs.push_back(mk(1, 3, 32'hABCD_0010, 3, 0, 1, 1, 0, 0, 0, 0, 0, 26'h0,       0, 3));
        vecs.push_back(mk(1, 3, 32'hABCD_0010, 3, 0, 0, 1, 1, 0, 0, 0, 0, 26'h0,       0, 4));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 0, 0, 1, 1, 4, 26'h3CD0010, 3, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 1, 0, 1, 0, 0, 0, 26'h0,       0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 0, 0, 1, 0, 8, 26'h2345678, 5, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 0, 0, 0, 0, 0, 26'h0,       0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 1, 0, 0, 0, 0, 0, 26'h0,       0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 1, 0, 0, 0, 0, 0, 26'h0,       0, 1));
        vecs.push_back(mk(1, 1, 32'h0000_0040, 9, 0, 1, 1, 1, 0, 0, 0, 0, 26'h0,       0, 2));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 1, 1, 2, 26'h40,      9, 1));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 0, 0, 0, 1, 1, 2, 26'h40,      9, 1));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 1, 0, 0, 1, 1, 2, 26'h40,      9, 1));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 1, 0, 1, 0, 0, 0, 26'h0,       0, 1));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 0, 0, 1, 0, 8, 26'h2345678, 5, 1));

        // Reset state.
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_wbeat_cnt", 32'(wbeat_cnt), 32'd0);
        chk("rst_err",       32'(err_wbeat_ovf), 32'd0);
        chk("rst_cmd_len",   32'(cmd_len), 32'd0);
        aresetn = 1'b1;

        // Table: drive one cycle's inputs, then check outputs mid-cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            tick();
            awvalid = vecs[i].awv; awlen = vecs[i].awl; awaddr = vecs[i].awa; awid = vecs[i].awi;
            arvalid = vecs[i].arv; wbeat_push = vecs[i].push; cmd_ready = vecs[i].crdy;
            #2;
            chk($sformatf("v%0d_awready", i),   32'(awready),   32'(vecs[i].e_awr));
            chk($sformatf("v%0d_arready", i),   32'(arready),   32'(vecs[i].e_arr));
            chk($sformatf("v%0d_cmd_valid", i), 32'(cmd_valid), 32'(vecs[i].e_cv));
            chk($sformatf("v%0d_wbeat_cnt", i), 32'(wbeat_cnt), 32'(vecs[i].e_cnt));
            if (vecs[i].e_cv) begin
                chk($sformatf("v%0d_cmd_write", i), 32'(cmd_write), 32'(vecs[i].e_wr));
                chk($sformatf("v%0d_cmd_len", i),   32'(cmd_len),   32'(vecs[i].e_len));
                chk($sformatf("v%0d_cmd_addr", i),  32'(cmd_addr),  32'(vecs[i].e_addr));
                chk($sformatf("v%0d_cmd_id", i),    32'(cmd_id),    32'(vecs[i].e_id));
            end
            $display("vec %0d: awr=%0d arr=%0d cv=%0d wr=%0d len=%0d addr=%0h cnt=%0d",
                     i, awready, arready, cmd_valid, cmd_write, cmd_len, cmd_addr, wbeat_cnt);
        end

        // Backpressure: read granted (write eligible too), then cmd_ready low 10 cycles.
        tick();
        awvalid = 1'b1; awlen = 4'd0; awaddr = 32'h0000_0100; awid = 4'd2;
        arvalid = 1'b1; cmd_ready = 1'b0; wbeat_push = 1'b0;
        #2;
        chk("bp_grant_arready", 32'(arready), 32'd1);
        chk("bp_grant_awready", 32'(awready), 32'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            #2;
            chk($sformatf("bp%0d_cmd_valid", c), 32'(cmd_valid), 32'd1);
            chk($sformatf("bp%0d_cmd_addr", c),  32'(cmd_addr),  32'h2345678);
            chk($sformatf("bp%0d_cmd_len", c),   32'(cmd_len),   32'd8);
            chk($sformatf("bp%0d_cmd_write", c), 32'(cmd_write), 32'd0);
            chk($sformatf("bp%0d_readies", c),   32'({awready, arready}), 32'd0);
        end
        $display("backpressure: held 10 cycles");
        tick();
        cmd_ready = 1'b1;
        #2;
        chk("bp_release_cmd_valid", 32'(cmd_valid), 32'd1);
        chk("bp_release_readies",   32'({awready, arready}), 32'd0);
        tick();
        #2;
        chk("bp_next_arready", 32'(arready), 32'd1);
        $display("backpressure: next grant arready=%0d", arready);

        // Starvation limit: reads always pending, writes of 1 beat eligible.
        do_reset();
        wbeat_push = 1'b1;
        tick();
        tick();
        wbeat_push = 1'b0;
        awvalid = 1'b1; awlen = 4'd0; awaddr = 32'h0000_0200; awid = 4'd1;
        arvalid = 1'b1; cmd_ready = 1'b1;
        got_order = "";
        exp_order = "RRRRWRRRRW";
        n_grants = 0;
        for (int c = 0; c < 60 && n_grants < 10; c++) begin
            #2;
            if (awready) begin
                got_order = {got_order, "W"};
                n_grants++;
            end else if (arready) begin
                got_order = {got_order, "R"};
                n_grants++;
            end
            tick();
        end
        $display("starvation: grant order %s", got_order);
        chk("starve_grant_count", 32'(n_grants), 32'd10);
        for (int g = 0; g < 10; g++) begin
            if (g < got_order.len())
                chk($sformatf("starve_grant%0d", g), 32'(got_order[g]), 32'(exp_order[g]));
        end

        // Overflow: 64 pushes with no AW, then reset while a command is pending.
        do_reset();
        wbeat_push = 1'b1;
        repeat (63) tick();
        #2;
        chk("ovf_cnt_63",     32'(wbeat_cnt), 32'd63);
        chk("ovf_err_before", 32'(err_wbeat_ovf), 32'd0);
        tick();
        wbeat_push = 1'b0;
        #2;
        chk("ovf_cnt_hold", 32'(wbeat_cnt), 32'd63);
        chk("ovf_err_set",  32'(err_wbeat_ovf), 32'd1);
        $display("overflow: cnt=%0d err=%0d", wbeat_cnt, err_wbeat_ovf);
        tick();
        arvalid = 1'b1; cmd_ready = 1'b0;
        #2;
        chk("ovf_rd_grant", 32'(arready), 32'd1);
        tick();
        #2;
        chk("ovf_issue_valid", 32'(cmd_valid), 32'd1);
        #1;
        aresetn = 1'b0;
        #1;
        chk("arst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("arst_cmd_write", 32'(cmd_write), 32'd0);
        chk("arst_cmd_addr",  32'(cmd_addr), 32'd0);
        chk("arst_cmd_id",    32'(cmd_id), 32'd0);
        chk("arst_cmd_len",   32'(cmd_len), 32'd0);
        chk("arst_wbeat_cnt", 32'(wbeat_cnt), 32'd0);
        chk("arst_err",       32'(err_wbeat_ovf), 32'd0);
        chk("arst_readies",   32'({awready, arready}), 32'd0);
        $display("async reset: cv=%0d cnt=%0d err=%0d", cmd_valid, wbeat_cnt, err_wbeat_ovf);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_ddr_cmd_arbiter.md
Name: axi_ddr_cmd_arbiter

Overview:
- Shares the single DDR command path between the AXI write-address (AW) and read-address (AR) channels.
- Issues one command at a time toward the DDR command clock-crossing FIFO using a valid/ready handshake.
- Gates each write command until its full burst of write data has been accepted, so the controller never requests write data that is absent.
- Default priority goes to reads for latency; a streak limit prevents write starvation.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width
AXI_ID_WIDTH, 4, AXI transaction ID width
DDR_ADDR_WIDTH, 26, DDR command address width; address truncated to LSBs
MAX_READ_STREAK, 4, consecutive read grants allowed while a write is eligible (1..15)
WBEAT_CNT_WIDTH, 6, width of the accepted-write-beat counter

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  asynchronous active-low reset
awaddr  in  AXI_ADDR_WIDTH  write address
awid  in  AXI_ID_WIDTH  write ID
awlen  in  4  write burst length minus 1
awvalid  in  1  write address valid
awready  out  1  write address accepted
araddr  in  AXI_ADDR_WIDTH  read address
arid  in  AXI_ID_WIDTH  read ID
arlen  in  4  read burst length minus 1
arvalid  in  1  read address valid
arready  out  1  read address accepted
wbeat_push  in  1  one W beat entered the write-data FIFO this cycle
cmd_valid  out  1  command valid toward the command FIFO
cmd_ready  in  1  command FIFO not full
cmd_write  out  1  1 = write, 0 = read
cmd_addr  out  DDR_ADDR_WIDTH  command address
cmd_id  out  AXI_ID_WIDTH  command ID
cmd_len  out  5  burst beats, 1..16
wbeat_cnt  out  WBEAT_CNT_WIDTH  write beats buffered but not yet committed to a command
err_wbeat_ovf  out  1  sticky overflow flag for the beat counter

Behaviour:
- Reset (async, aresetn=0): state=IDLE; cmd_valid, cmd_write, cmd_addr, cmd_id, cmd_len, wbeat_cnt, err_wbeat_ovf, and the read streak counter all cleared to 0. awready and arready are 0 while in reset. Reset mid-command drops the pending command with no replay.
- Eligibility (IDLE only):
  - wr_elig = awvalid && (wbeat_cnt >= awlen+1)
  - rd_elig = arvalid
- Grant rule:
  - If only one channel is eligible, grant it.
  - If both are eligible, grant the read unless streak == MAX_READ_STREAK; in that case grant the write.
- awready = (state==IDLE) && grant_w; arready = (state==IDLE) && grant_r. Both are combinational, never asserted together, and only in IDLE.
- Cycle N handshake: at the rising edge ending cycle N, capture the command: cmd_addr=addr[DDR_ADDR_WIDTH-1:0], cmd_id, cmd_len=len+1 (5-bit, no overflow), cmd_write. Set cmd_valid=1 and state=ISSUE, so cmd_valid is visible in cycle N+1.
- ISSUE state: cmd_valid and all cmd_* outputs are held stable until cmd_ready=1. On the edge where cmd_valid && cmd_ready, cmd_valid clears and state returns to IDLE. Minimum spacing is one command every 2 cycles.
- Streak counter:
  - Increments on each read grant made while wr_elig=1 (saturates at MAX_READ_STREAK).
  - Clears on any write grant.
  - Clears on a read grant made while wr_elig=0.
- Beat counter, updated every cycle: wbeat_cnt <= wbeat_cnt + wbeat_push - (write grant ? awlen+1 : 0).
  - Simultaneous push and grant are applied together.
  - Eligibility guarantees the counter never underflows.
  - A push when wbeat_cnt is all-ones holds the counter and sets err_wbeat_ovf=1 until reset.
- wbeat_push is counted in every state, including ISSUE.
- No AXI response generation, no ID reordering, no 4K boundary check.

Test Plan:
- Write gating: awvalid=1, awlen=3, push 3 beats -> awready stays 0; on the 4th push, awready=1 next cycle, then cmd_valid=1 with cmd_write=1, cmd_len=4, and wbeat_cnt returns to 0.
- Read latency: arvalid=1, araddr=0x1234_5678, arid=5, arlen=7, cmd_ready=1 -> arready in cycle 0; cycle 1 shows cmd_valid=1, cmd_addr=0x2345678, cmd_id=5, cmd_len=8, cmd_write=0; cmd_valid=0 in cycle 2.
- Backpressure: cmd_ready=0 for 10 cycles after a grant -> cmd_* stable, awready=arready=0 throughout; one cycle after cmd_ready=1, the next grant becomes possible.
- Starvation limit: MAX_READ_STREAK=4, arvalid held high, write eligible -> grant order R,R,R,R,W,R,R,R,R,W.
- Simultaneous push and grant: wbeat_cnt=2, awlen=1, wbeat_push=1 on the grant cycle -> wbeat_cnt=1 afterwards.
- Overflow/reset: 64 pushes with no AW -> err_wbeat_ovf=1 and wbeat_cnt=63; assert aresetn=0 during ISSUE -> all outputs 0 immediately, without waiting for a clock.
